mag_search_sar: RTL and testbench
=================================

# mag_search_sar

Successive-approximation searcher that recovers an unknown W-bit value Q from the two-flag magnitude-comparator interface. It drives the comparator's P input with trial values (`probe`) and reads back the PMQ/PmQ flag pair. Encoding: 11 means P==Q, 10 means P>Q, 01 means P<Q, 00 is invalid. This decodes comparator results into a value, the reverse direction of the comparator itself. It sits beside the existing comparator in the comparator subsystem and closes a loop through it.

## Interface
- `W`, default 4: width of probe and result.
- `SETTLE`, default 0: extra wait cycles after each probe change before the flags are sampled (for slow or registered comparators).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a search; sampled in IDLE only.
- `pmq`  in  1: comparator flag "P>=Q" (PMQout).
- `pmq_le`  in  1: comparator flag "P<=Q" (PmQout).
- `probe`  out  W: trial value driven to comparator P, registered.
- `busy`  out  1: high while a search is in progress.
- `done`  out  1: one-cycle pulse when a search ends.
- `found`  out  W: recovered Q; held until the next `start`.
- `err`  out  1: valid with `done`; high when flags 00 were sampled.
- `steps`  out  $clog2(W+1): number of comparisons used; held with `found`.

## Operation
- FSM states: IDLE, WAIT, SAMPLE.
- IDLE with `start`=1 at a clock edge:
  - `result`<=0, `idx`<=W-1, `probe`<=1<<(W-1), `steps`<=0, `busy`<=1, `err`<=0.
  - Go to WAIT if SETTLE>0 (counter loaded with SETTLE-1), else go to SAMPLE.
- WAIT: decrement the counter; go to SAMPLE when it reaches 0.
- SAMPLE: `steps`<=`steps`+1, then decode {pmq, pmq_le}:
  - 11: `found`<=`probe`; `done`=1; go to IDLE (early exit).
  - 01 (probe<Q): keep bit `idx` in `result`.
  - 10 (probe>Q): clear bit `idx` in `result`.
  - 00: `err`=1, `done`=1, `found`<=0; go to IDLE.
- After 01 or 10:
  - If `idx`==0: `found`<=updated `result`, `done`=1, go to IDLE.
  - Otherwise: `idx`<=`idx`-1, `probe`<=updated `result` | (1<<(`idx`-1)), then re-enter WAIT or SAMPLE as above.
- Arithmetic: all probe values are W bits and never overflow, since they are formed by bit OR only.
- Search space: probe is never 0, so Q=0 resolves through W outcomes of 10 with no early exit.
- `start` while busy is ignored. `start` held high in IDLE re-launches on the edge after `done`.
- `busy` drops in the same cycle `done` is high.

## Timing
- Reset values: state=IDLE, `probe`=0, `busy`=0, `done`=0, `err`=0, `found`=0, `steps`=0.
- Flags are treated as combinational functions of `probe`. With SETTLE=0 they are sampled on the edge after `probe` changes.
- Latency from the `start` edge to `done`: k*(SETTLE+1) cycles, where k = `steps` (1..W). Worst case is W*(SETTLE+1).
- `done` and `err` are registered one-cycle pulses. `found` and `steps` are valid in the `done` cycle and held afterwards.
- `probe` keeps its last value in IDLE.
- Reset asserted mid-search: all outputs return to reset values immediately and asynchronously, with no `done` pulse.

## Structure
- Shared package `cmp_pkg` holds:
  - the state enum;
  - flag-pair constants FLAG_EQ=2'b11, FLAG_GT=2'b10, FLAG_LT=2'b01, FLAG_BAD=2'b00.
- Single module, no sub-module. The settle counter and SAR register are inline.
- The bench closes the loop with a behavioural comparator model using the same encoding.

## Test plan
- W=4, SETTLE=0, Q=9: probes 8,12,10,9; flags 01,10,10,11 -> `found`=9, `steps`=4, `done` 4 cycles after `start`, `err`=0.
- Q=8: probe 8 returns 11 -> early exit, `found`=8, `steps`=1, `done` 1 cycle after `start`.
- Q=0: probes 8,4,2,1, all 10 -> `found`=0, `steps`=4. Q=15: probes 8,12,14,15 -> `found`=15.
- Flags forced 00 on the first sample -> `done`=1, `err`=1, `found`=0. Then a normal Q=5 search gives `found`=5 with `err`=0.
- SETTLE=2, Q=6: `probe` is held 3 cycles per step, `done` 9 cycles after `start`, `found`=6, `steps`=3. `start` pulsed mid-search has no effect.
- `rst` pulsed after the second sample of a Q=11 search -> outputs return to reset values immediately. A new `start` then yields `found`=11.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator subsystem.
//   - search_state_e : state encoding for the successive-approximation searcher
//   - FLAG_*         : {PMQ, PmQ} flag-pair encodings from the magnitude comparator
package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE
  } search_state_e;

  localparam logic [1:0] FLAG_EQ  = 2'b11;
  localparam logic [1:0] FLAG_GT  = 2'b10;
  localparam logic [1:0] FLAG_LT  = 2'b01;
  localparam logic [1:0] FLAG_BAD = 2'b00;

endpackage

// File: rtl/mag_search_sar.sv
// Successive-approximation searcher that recovers an unknown W-bit value Q
// by driving trial values into a magnitude comparator and reading back its
// {PMQ, PmQ} flag pair.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start         : launch a search (honoured in IDLE only)
//   pmq, pmq_le   : comparator flags P>=Q and P<=Q
//   probe         : registered trial value driven to comparator P
//   busy          : search in progress
//   done          : one-cycle pulse at the end of a search
//   found         : recovered Q, held until the next search completes
//   err           : pulse with done when the invalid flag pair 00 was seen
//   steps         : comparisons used by the last/current search
module mag_search_sar
  import cmp_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned SETTLE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pmq,
  input  logic                     pmq_le,
  output logic [W-1:0]             probe,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             found,
  output logic                     err,
  output logic [$clog2(W+1)-1:0]   steps
);

  localparam int unsigned SW       = $clog2(W + 1);
  localparam int unsigned IW       = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned CNT_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] TOP_BIT = ONE << (W - 1);

  search_state_e state_q, state_d;
  logic [W-1:0]  probe_q, probe_d;
  logic [W-1:0]  result_q, result_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [W-1:0]  found_q, found_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [1:0]    flags;
  logic [W-1:0]  bit_idx;
  logic [W-1:0]  bit_nxt;
  logic [W-1:0]  result_upd;

  assign flags   = {pmq, pmq_le};
  assign bit_idx = ONE << idx_q;
  // Only used when idx_q > 0, so the wrap at idx_q == 0 is harmless.
  assign bit_nxt = ONE << (idx_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    probe_d    = probe_q;
    result_d   = result_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    steps_d    = steps_q;
    found_d    = found_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    // Probe = decided bits | trial bit, so "keep" sets the trial bit and
    // "clear" leaves the decided bits untouched.
    result_upd = (flags == FLAG_LT) ? (result_q | bit_idx) : result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          result_d = '0;
          idx_d    = IW'(W - 1);
          probe_d  = TOP_BIT;
          steps_d  = '0;
          busy_d   = 1'b1;
          if (SETTLE > 0) begin
            cnt_d   = CW'(CNT_LOAD);
            state_d = S_WAIT;
          end else begin
            state_d = S_SAMPLE;
          end
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_SAMPLE: begin
        steps_d = steps_q + 1'b1;
        case (flags)
          FLAG_EQ: begin
            found_d = probe_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
          FLAG_LT, FLAG_GT: begin
            result_d = result_upd;
            if (idx_q == '0) begin
              found_d = result_upd;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              idx_d   = idx_q - 1'b1;
              probe_d = result_upd | bit_nxt;
              if (SETTLE > 0) begin
                cnt_d   = CW'(CNT_LOAD);
                state_d = S_WAIT;
              end else begin
                state_d = S_SAMPLE;
              end
            end
          end
          FLAG_BAD: begin
            found_d = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      probe_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      found_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign probe = probe_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign err   = err_q;
  assign steps = steps_q;

endmodule

// File: tb/tb_mag_search_sar.sv
// Bench for mag_search_sar: two instances (SETTLE=0 and SETTLE=2) each closed
// through a behavioural comparator. Expected results come from closed-form
// properties of binary search over W=4 bits.
module tb_mag_search_sar;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: SETTLE = 0
  logic       start0 = 1'b0;
  logic [3:0] q0 = '0;
  logic       bad0 = 1'b0;
  logic       pmq0, pmq_le0, busy0, done0, err0;
  logic [3:0] probe0, found0;
  logic [2:0] steps0;

  // Instance 2: SETTLE = 2
  logic       start2 = 1'b0;
  logic [3:0] q2 = '0;
  logic       pmq2, pmq_le2, busy2, done2, err2;
  logic [3:0] probe2, found2;
  logic [2:0] steps2;

  assign pmq0    = bad0 ? 1'b0 : (probe0 >= q0);
  assign pmq_le0 = bad0 ? 1'b0 : (probe0 <= q0);
  assign pmq2    = (probe2 >= q2);
  assign pmq_le2 = (probe2 <= q2);

  mag_search_sar #(.W(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pmq(pmq0), .pmq_le(pmq_le0),
    .probe(probe0), .busy(busy0), .done(done0), .found(found0),
    .err(err0), .steps(steps0)
  );

  mag_search_sar #(.W(4), .SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pmq(pmq2), .pmq_le(pmq_le2),
    .probe(probe2), .busy(busy2), .done(done2), .found(found2),
    .err(err2), .steps(steps2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from the last run
  logic [3:0] probe_log[$];
  logic [3:0] r_found;
  int         r_steps;
  int         r_lat;
  logic       r_err;
  logic       r_to;
  logic       r_busy_mid;

  // Reference: a search ends as soon as the probe equals Q. The probe for bit
  // i holds Q's bits above i plus bit i, so it matches Q exactly when i is
  // Q's lowest set bit; Q=0 never matches and uses all W comparisons.
  function automatic int ref_steps(input logic [3:0] q);
    if (q == 4'd0) return 4;
    for (int i = 0; i < 4; i++) if (q[i]) return 4 - i;
    return 4;
  endfunction

  function automatic logic [3:0] ref_probe(input logic [3:0] q, input int k);
    int i;
    int qi;
    i  = 3 - k;
    qi = q;
    return 4'(((qi >> (i + 1)) << (i + 1)) | (1 << i));
  endfunction

  function automatic logic [3:0] probe_of(input int sel);
    return (sel == 0) ? probe0 : probe2;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done0 : done2;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else start2 = v;
  endtask

  // Launch one search and log the probe after the start edge and after every
  // following edge until done. pulse_at >= 0 re-pulses start mid-search.
  task automatic run(input int sel, input logic [3:0] q, input int pulse_at);
    if (sel == 0) q0 = q;
    else q2 = q;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    probe_log.delete();
    probe_log.push_back(probe_of(sel));
    r_lat      = 0;
    r_to       = 1'b1;
    r_busy_mid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      r_lat++;
      if (done_of(sel)) begin
        r_to = 1'b0;
        break;
      end
      if (((sel == 0) ? busy0 : busy2) !== 1'b1) r_busy_mid = 1'b0;
      probe_log.push_back(probe_of(sel));
      set_start(sel, r_lat == pulse_at);
    end
    set_start(sel, 1'b0);
    r_found = (sel == 0) ? found0 : found2;
    r_steps = (sel == 0) ? int'(steps0) : int'(steps2);
    r_err   = (sel == 0) ? err0 : err2;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    obs = {probe0, busy0, done0, err0, found0, steps0, 1'b0};
    n_checks++;
    if (obs !== 16'h0) $display("FAIL reset_dut0 got=%h exp=0000", obs);
    else n_pass++;
    obs = {probe2, busy2, done2, err2, found2, steps2, 1'b0};
    n_checks++;
    if (obs !== 16'h0) $display("FAIL reset_dut2 got=%h exp=0000", obs);
    else n_pass++;
  endtask

  // Settle-free searches; checks outcome, step count, latency and probe trail.
  task automatic check_search0(input logic [3:0] q, input string tag);
    int  es;
    logic trail_ok;
    run(0, q, -1);
    es = ref_steps(q);
    n_checks++;
    if (r_to) $display("FAIL %s_timeout q=%0d no done within 60 cycles", tag, q);
    else n_pass++;
    n_checks++;
    if (r_found !== q || r_err !== 1'b0)
      $display("FAIL %s_found q=%0d got=%0d err=%b exp=%0d err=0", tag, q, r_found, r_err, q);
    else n_pass++;
    n_checks++;
    if (r_steps != es || r_lat != es)
      $display("FAIL %s_steps q=%0d steps=%0d lat=%0d exp=%0d", tag, q, r_steps, r_lat, es);
    else n_pass++;
    trail_ok = (probe_log.size() == es) && r_busy_mid;
    for (int k = 0; k < probe_log.size() && k < es; k++)
      if (probe_log[k] !== ref_probe(q, k)) trail_ok = 1'b0;
    n_checks++;
    if (!trail_ok)
      $display("FAIL %s_probes q=%0d got %p (busy_ok=%b) exp %0d probes from %0d",
               tag, q, probe_log, r_busy_mid, es, ref_probe(q, 0));
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [3:0] qs[4] = '{4'd9, 4'd8, 4'd0, 4'd15};
    foreach (qs[i]) check_search0(qs[i], "directed");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) check_search0(4'($urandom_range(0, 15)), "random");
  endtask

  task automatic test_bad_flags();
    bad0 = 1'b1;
    run(0, 4'd3, -1);
    bad0 = 1'b0;
    n_checks++;
    if (r_to || r_lat != 1 || r_err !== 1'b1 || r_found !== 4'd0 || r_steps != 1)
      $display("FAIL bad_flags to=%b lat=%0d err=%b found=%0d steps=%0d exp lat=1 err=1 found=0 steps=1",
               r_to, r_lat, r_err, r_found, r_steps);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (err0 !== 1'b0 || done0 !== 1'b0)
      $display("FAIL bad_pulse err=%b done=%b exp 0 0", err0, done0);
    else n_pass++;
    check_search0(4'd5, "after_bad");
  endtask

  task automatic test_settle();
    logic trail_ok;
    run(2, 4'd6, 4);
    n_checks++;
    if (r_to || r_lat != 9 || r_found !== 4'd6 || r_steps != 3 || r_err !== 1'b0)
      $display("FAIL settle_q6 to=%b lat=%0d found=%0d steps=%0d err=%b exp lat=9 found=6 steps=3 err=0",
               r_to, r_lat, r_found, r_steps, r_err);
    else n_pass++;
    trail_ok = (probe_log.size() == 9);
    for (int k = 0; k < probe_log.size() && k < 9; k++)
      if (probe_log[k] !== ref_probe(4'd6, k / 3)) trail_ok = 1'b0;
    n_checks++;
    if (!trail_ok) $display("FAIL settle_probes got %p exp 8,8,8,4,4,4,6,6,6", probe_log);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] q;
      int es;
      q  = 4'($urandom_range(0, 15));
      es = ref_steps(q);
      run(2, q, -1);
      n_checks++;
      if (r_to || r_lat != 3 * es || r_found !== q || r_steps != es)
        $display("FAIL settle_rand q=%0d lat=%0d found=%0d steps=%0d exp lat=%0d steps=%0d",
                 q, r_lat, r_found, r_steps, 3 * es, es);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    q0 = 4'd8;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0)
      $display("FAIL b2b_first_done done=%b busy=%b exp 1 0", done0, busy0);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || probe0 !== 4'd8)
      $display("FAIL b2b_relaunch done=%b busy=%b probe=%0d exp 0 1 8", done0, busy0, probe0);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (done0 !== 1'b1 || found0 !== 4'd8)
      $display("FAIL b2b_second_done done=%b found=%0d exp 1 8", done0, found0);
    else n_pass++;
    start0 = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0)
      $display("FAIL b2b_idle done=%b busy=%b exp 0 0", done0, busy0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] obs;
    q0 = 4'd11;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy0 !== 1'b1 || probe0 !== 4'd10)
      $display("FAIL rst_mid_pre busy=%b probe=%0d exp 1 10", busy0, probe0);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    obs = {probe0, busy0, done0, err0, found0, steps0, 1'b0};
    n_checks++;
    if (obs !== 16'h0) $display("FAIL rst_mid_async got=%h exp=0000", obs);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0)
      $display("FAIL rst_mid_hold done=%b busy=%b exp 0 0", done0, busy0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    check_search0(4'd11, "after_rst");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_random();
    test_bad_flags();
    test_settle();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule
